sisc_ctrl_fsm: RTL and testbench
================================

Name: sisc_ctrl_fsm

Overview:
Parametrised next-generation SISC control unit. It sequences every instruction through a multi-cycle FSM (fetch/decode/execute/mem/writeback) and drives all datapath controls, not only ALU writeback: instruction register, PC, data memory, register-file write and swap.
- Executes the full ISA: NOOP, LOD, STR, SWP, BRA, BRR, BNE, BNR, ALU, HLT.
- HLT is a real halt state instead of a simulation stop.
- Sits between the instruction register and the datapath.

Parameters:
OPC_W, 4, opcode width.
MM_W, 4, mode/mask field width; must equal STAT_W.
STAT_W, 4, status flag width.
AM_IMM, 8, mm value selecting immediate ALU mode.
ALU_OP_W, 2, alu_op width.

Ports:
clk  in  1  system clock; one clock.
rst_f  in  1  reset; synchronous and active-high.
opcode  in  OPC_W  current instruction opcode.
mm  in  MM_W  addressing mode / branch mask.
stat  in  STAT_W  status flags from the status register.
rf_we  out  1  register-file write enable.
wb_sel  out  1  writeback source: 0 = ALU, 1 = data memory.
swp_sel  out  1  selects the second swap write port/data.
alu_op  out  ALU_OP_W  ALU operation class.
ir_load  out  1  instruction-register load.
pc_write  out  1  PC update enable.
pc_sel  out  1  PC source: 0 = PC+1, 1 = branch target.
br_sel  out  1  branch target: 0 = absolute, 1 = PC-relative.
mm_sel  out  1  data-memory address from the ALU result.
dm_we  out  1  data-memory write enable.
halted  out  1  high while in the HALT state.

Behaviour:
- Opcodes: NOOP=0, LOD=1, STR=2, SWP=3, BRA=4, BRR=5, BNE=6, BNR=7, ALU=8, HLT=15. All other codes behave as NOOP.
- States: START0, START1, FETCH, DECODE, EXECUTE, MEM, WB, WB2, HALT. Encoding goes in the package.
- Reset: rst_f sampled high at a clk edge sets state to START1. Reset has priority over every transition, including mid-instruction and HALT.
- After reset: START1 -> FETCH on the next edge.
- Initial state after power-up is START0. START0 -> START1.
- Main sequence: FETCH -> DECODE.
- DECODE:
  - HLT -> HALT.
  - Branch opcodes -> FETCH.
  - All other opcodes -> EXECUTE.
- EXECUTE -> MEM -> WB.
- WB: SWP -> WB2; otherwise -> FETCH.
- WB2 -> FETCH.
- HALT: self-loop; leaves only through reset.
- Cycle counts per instruction:
  - Branches: 2 cycles.
  - SWP: 6 cycles.
  - All others: 5 cycles.
  - With SISC_SKIP_MEM_EN, ALU and NOOP take 4 cycles (see Optional Feature).
- Outputs are combinational from state, opcode, mm and stat.
- Default output values in every state: all outputs 0, except alu_op = 2'b10 (pass/hold). START0, START1 and reset therefore present these defaults.
- FETCH: ir_load=1, pc_write=1, pc_sel=0.
- DECODE:
  - Branch taken condition:
    - BRA/BRR: taken if (mm & stat) != 0.
    - BNE/BNR: taken if (mm & stat) == 0.
  - If taken: pc_write=1, pc_sel=1.
  - br_sel=1 for BRR/BNR, 0 for BRA/BNA.
  - Not taken: no outputs asserted. The PC already advanced in FETCH.
- EXECUTE and MEM, ALU opcode: alu_op[1]=0, alu_op[0]=(mm==AM_IMM).
- EXECUTE and MEM, LOD/STR: alu_op=2'b01 (address add).
- MEM, LOD: mm_sel=1.
- MEM, STR: mm_sel=1, dm_we=1 for exactly one cycle.
- WB:
  - ALU: rf_we=1, wb_sel=0.
  - LOD: rf_we=1, wb_sel=1, mm_sel=1.
  - SWP: rf_we=1, swp_sel=0.
- WB2 (SWP only): rf_we=1, swp_sel=1.
- HALT: halted=1; all other outputs at defaults.
- Invariants:
  - rf_we and dm_we are never high in the same cycle.
  - dm_we is never high outside MEM.
- Opcode changes outside FETCH are the caller's error. The FSM uses whatever values are present each cycle.

Optional Feature:
Macro SISC_SKIP_MEM_EN.
- Defined: ALU and NOOP go EXECUTE -> WB directly, skipping MEM.
- Not defined: every non-branch, non-HLT instruction visits MEM.
- Branch, LOD, STR and SWP timing is identical either way.

Decomposition:
- Package sisc_pkg holds:
  - opcode constants;
  - state encoding (4-bit);
  - ALU_OP_PASS=2'b10, ALU_OP_ADDR=2'b01;
  - AM_IMM default.
- Natural sub-module: sisc_br_eval. Combinational evaluation of (mm & stat) against the opcode; outputs taken and br_sel. Reused by the future pipelined controller.

Test Plan:
1. Reset, then ALU with mm=8 -> states START1, FETCH, DECODE, EXECUTE(alu_op=01), MEM(alu_op=01), WB(rf_we=1, wb_sel=0), then FETCH.
2. LOD then STR -> LOD WB: rf_we=1, wb_sel=1. STR MEM: dm_we=1 for exactly one cycle. STR never asserts rf_we.
3. BRR with mm=4'b0010:
   - stat=4'b0010 -> DECODE drives pc_write=1, pc_sel=1, br_sel=1.
   - stat=0 -> no pc_write in DECODE.
   - Next state is FETCH in both cases.
4. SWP -> WB rf_we=1 with swp_sel=0, then WB2 rf_we=1 with swp_sel=1; 6 cycles total.
5. HLT -> halted=1 held for 20 cycles. Assert rst_f for one edge -> START1, halted=0, FETCH on the following edge.
6. rst_f asserted during MEM of STR -> dm_we drops immediately after the edge and state is START1. With SISC_SKIP_MEM_EN defined, an ALU instruction completes in 4 cycles.

Source files
------------

// File: rtl/sisc_pkg.sv
// sisc_pkg -- shared definitions for the SISC control unit.
//   Opcode constants, 4-bit FSM state encoding, ALU operation classes and
//   the default addressing-mode value that selects immediate ALU operation.
package sisc_pkg;

  // Opcode map; every code not listed here executes as NOOP.
  localparam logic [3:0] OP_NOOP = 4'd0;
  localparam logic [3:0] OP_LOD  = 4'd1;
  localparam logic [3:0] OP_STR  = 4'd2;
  localparam logic [3:0] OP_SWP  = 4'd3;
  localparam logic [3:0] OP_BRA  = 4'd4;
  localparam logic [3:0] OP_BRR  = 4'd5;
  localparam logic [3:0] OP_BNE  = 4'd6;
  localparam logic [3:0] OP_BNR  = 4'd7;
  localparam logic [3:0] OP_ALU  = 4'd8;
  localparam logic [3:0] OP_HLT  = 4'd15;

  // START0 is encoded as zero so that a register that powers up cleared
  // lands in the power-up state.
  typedef enum logic [3:0] {
    S_START0  = 4'd0,
    S_START1  = 4'd1,
    S_FETCH   = 4'd2,
    S_DECODE  = 4'd3,
    S_EXECUTE = 4'd4,
    S_MEM     = 4'd5,
    S_WB      = 4'd6,
    S_WB2     = 4'd7,
    S_HALT    = 4'd8
  } state_t;

  localparam logic [1:0] ALU_OP_PASS = 2'b10;  // pass/hold, idle default
  localparam logic [1:0] ALU_OP_ADDR = 2'b01;  // base + offset address add

  localparam int AM_IMM_DEF = 8;

endpackage

// File: rtl/sisc_br_eval.sv
// sisc_br_eval -- combinational branch evaluation.
//   Compares the branch mask against the status flags and decides whether
//   a branch opcode is taken and which target form it uses.
// Ports:
//   opcode    in   current instruction opcode
//   mm        in   branch mask
//   stat      in   status flags (same width as mm)
//   is_branch out  opcode is one of BRA/BRR/BNE/BNR
//   taken     out  branch condition holds (0 for non-branch opcodes)
//   br_sel    out  0 = absolute target, 1 = PC-relative target
module sisc_br_eval
  import sisc_pkg::*;
#(
  parameter int OPC_W = 4,
  parameter int MM_W  = 4
) (
  input  logic [OPC_W-1:0] opcode,
  input  logic [MM_W-1:0]  mm,
  input  logic [MM_W-1:0]  stat,
  output logic             is_branch,
  output logic             taken,
  output logic             br_sel
);

  logic any_hit;
  assign any_hit = |(mm & stat);

  always_comb begin
    is_branch = 1'b0;
    taken     = 1'b0;
    br_sel    = 1'b0;
    if (opcode == OPC_W'(OP_BRA) || opcode == OPC_W'(OP_BRR)) begin
      is_branch = 1'b1;
      taken     = any_hit;
    end else if (opcode == OPC_W'(OP_BNE) || opcode == OPC_W'(OP_BNR)) begin
      is_branch = 1'b1;
      taken     = ~any_hit;
    end
    br_sel = (opcode == OPC_W'(OP_BRR)) || (opcode == OPC_W'(OP_BNR));
  end

endmodule

// File: rtl/sisc_ctrl_fsm.sv
// sisc_ctrl_fsm -- multi-cycle SISC control unit.
//   Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB(/WB2)
//   and drives every datapath control. HLT parks the FSM in HALT until reset.
//   Optional macro SISC_SKIP_MEM_EN: ALU and NOOP-class instructions skip
//   the MEM state (EXECUTE -> WB), taking 4 cycles instead of 5.
// Ports:
//   clk, rst_f            clock; synchronous active-high reset (-> START1)
//   opcode, mm, stat      instruction opcode, mode/mask, status flags
//   rf_we, wb_sel, swp_sel  register-file write enable and source selects
//   alu_op                ALU operation class
//   ir_load               instruction-register load
//   pc_write, pc_sel, br_sel  PC update, source and branch-target form
//   mm_sel, dm_we         data-memory address select and write enable
//   halted                high while in HALT
module sisc_ctrl_fsm
  import sisc_pkg::*;
#(
  parameter int OPC_W    = 4,
  parameter int MM_W     = 4,
  parameter int STAT_W   = 4,
  parameter int AM_IMM   = AM_IMM_DEF,
  parameter int ALU_OP_W = 2
) (
  input  logic                clk,
  input  logic                rst_f,
  input  logic [OPC_W-1:0]    opcode,
  input  logic [MM_W-1:0]     mm,
  input  logic [STAT_W-1:0]   stat,
  output logic                rf_we,
  output logic                wb_sel,
  output logic                swp_sel,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                ir_load,
  output logic                pc_write,
  output logic                pc_sel,
  output logic                br_sel,
  output logic                mm_sel,
  output logic                dm_we,
  output logic                halted
);

  state_t state_reg, state_next;

  logic is_branch, br_taken, br_rel;
  logic is_lod, is_str, is_swp, is_alu, is_hlt;

  assign is_lod = (opcode == OPC_W'(OP_LOD));
  assign is_str = (opcode == OPC_W'(OP_STR));
  assign is_swp = (opcode == OPC_W'(OP_SWP));
  assign is_alu = (opcode == OPC_W'(OP_ALU));
  assign is_hlt = (opcode == OPC_W'(OP_HLT));

  // mm and stat must share a width for the mask test.
  sisc_br_eval #(
    .OPC_W (OPC_W),
    .MM_W  (MM_W)
  ) u_br_eval (
    .opcode    (opcode),
    .mm        (mm),
    .stat      (MM_W'(stat)),
    .is_branch (is_branch),
    .taken     (br_taken),
    .br_sel    (br_rel)
  );

  always_ff @(posedge clk) begin
    if (rst_f) state_reg <= S_START1;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_START0:  state_next = S_START1;
      S_START1:  state_next = S_FETCH;
      S_FETCH:   state_next = S_DECODE;
      S_DECODE: begin
        if (is_hlt)         state_next = S_HALT;
        else if (is_branch) state_next = S_FETCH;
        else                state_next = S_EXECUTE;
      end
      S_EXECUTE: begin
`ifdef SISC_SKIP_MEM_EN
        // Only memory-touching and swap instructions need the MEM slot.
        if (is_lod || is_str || is_swp) state_next = S_MEM;
        else                            state_next = S_WB;
`else
        state_next = S_MEM;
`endif
      end
      S_MEM:     state_next = S_WB;
      S_WB:      state_next = is_swp ? S_WB2 : S_FETCH;
      S_WB2:     state_next = S_FETCH;
      S_HALT:    state_next = S_HALT;
      default:   state_next = S_START1;
    endcase
  end

  // Output decode
  always_comb begin
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    swp_sel  = 1'b0;
    alu_op   = ALU_OP_W'(ALU_OP_PASS);
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
    mm_sel   = 1'b0;
    dm_we    = 1'b0;
    halted   = 1'b0;
    case (state_reg)
      S_FETCH: begin
        ir_load  = 1'b1;
        pc_write = 1'b1;
      end
      S_DECODE: begin
        // A not-taken branch does nothing: PC already advanced in FETCH.
        if (br_taken) begin
          pc_write = 1'b1;
          pc_sel   = 1'b1;
          br_sel   = br_rel;
        end
      end
      S_EXECUTE, S_MEM: begin
        if (is_alu)
          alu_op = ALU_OP_W'({1'b0, (mm == MM_W'(AM_IMM))});
        else if (is_lod || is_str)
          alu_op = ALU_OP_W'(ALU_OP_ADDR);
        if (state_reg == S_MEM && (is_lod || is_str)) begin
          mm_sel = 1'b1;
          dm_we  = is_str;
        end
      end
      S_WB: begin
        if (is_alu) begin
          rf_we = 1'b1;
        end else if (is_lod) begin
          rf_we  = 1'b1;
          wb_sel = 1'b1;
          mm_sel = 1'b1;
        end else if (is_swp) begin
          rf_we = 1'b1;
        end
      end
      S_WB2: begin
        rf_we   = 1'b1;
        swp_sel = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sisc_ctrl_fsm.sv
// tb_sisc_ctrl_fsm -- directed-vector bench for sisc_ctrl_fsm.
//   Outputs are packed into one 12-bit word per cycle and compared against
//   hand-computed constants:
//   [11]rf_we [10]wb_sel [9]swp_sel [8:7]alu_op [6]ir_load [5]pc_write
//   [4]pc_sel [3]br_sel [2]mm_sel [1]dm_we [0]halted
module tb_sisc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_f = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic [3:0] mm = 4'd0;
  logic [3:0] stat = 4'd0;
  logic       rf_we, wb_sel, swp_sel, ir_load, pc_write, pc_sel, br_sel;
  logic       mm_sel, dm_we, halted;
  logic [1:0] alu_op;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [11:0] O_DEF     = 12'h100;
  localparam logic [11:0] O_FETCH   = 12'h160;
  localparam logic [11:0] O_ALU_IMM = 12'h080;
  localparam logic [11:0] O_ALU_REG = 12'h000;
  localparam logic [11:0] O_ADDR    = 12'h080;
  localparam logic [11:0] O_WB_ALU  = 12'h900;
  localparam logic [11:0] O_LOD_MEM = 12'h084;
  localparam logic [11:0] O_LOD_WB  = 12'hD04;
  localparam logic [11:0] O_STR_MEM = 12'h086;
  localparam logic [11:0] O_WB2     = 12'hB00;
  localparam logic [11:0] O_BR_REL  = 12'h138;
  localparam logic [11:0] O_BR_ABS  = 12'h130;
  localparam logic [11:0] O_HALT    = 12'h101;

  always #5 clk = ~clk;

  sisc_ctrl_fsm dut (
    .clk      (clk),
    .rst_f    (rst_f),
    .opcode   (opcode),
    .mm       (mm),
    .stat     (stat),
    .rf_we    (rf_we),
    .wb_sel   (wb_sel),
    .swp_sel  (swp_sel),
    .alu_op   (alu_op),
    .ir_load  (ir_load),
    .pc_write (pc_write),
    .pc_sel   (pc_sel),
    .br_sel   (br_sel),
    .mm_sel   (mm_sel),
    .dm_we    (dm_we),
    .halted   (halted)
  );

  logic [11:0] outs;
  assign outs = {rf_we, wb_sel, swp_sel, alu_op, ir_load, pc_write, pc_sel,
                 br_sel, mm_sel, dm_we, halted};

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%03h expected 0x%03h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%03h", tag, got);
    end
  endtask

  // One clock cycle: sample at negedge, then advance past the next posedge.
  task automatic cyc(input string tag, input logic [11:0] exp);
    @(negedge clk);
    check(tag, outs, exp);
    check({tag, "_inv"}, {11'd0, rf_we & dm_we}, 12'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_alu(input logic [3:0] m, input logic [11:0] exp_ex);
    opcode = 4'd8; mm = m;
    cyc("alu_fetch", O_FETCH);
    cyc("alu_decode", O_DEF);
    cyc("alu_exec", exp_ex);
`ifndef SISC_SKIP_MEM_EN
    cyc("alu_mem", exp_ex);
`endif
    cyc("alu_wb", O_WB_ALU);
  endtask

  initial begin
    // Reset -> START1 -> FETCH
    rst_f = 1'b1;
    @(posedge clk); #1;
    rst_f = 1'b0;
    cyc("start1", O_DEF);

    // 1: ALU immediate and register mode
    run_alu(4'd8, O_ALU_IMM);
    run_alu(4'd0, O_ALU_REG);

    // 2: LOD then STR
    opcode = 4'd1; mm = 4'd0;
    cyc("lod_fetch", O_FETCH);
    cyc("lod_decode", O_DEF);
    cyc("lod_exec", O_ADDR);
    cyc("lod_mem", O_LOD_MEM);
    cyc("lod_wb", O_LOD_WB);
    opcode = 4'd2;
    cyc("str_fetch", O_FETCH);
    cyc("str_decode", O_DEF);
    cyc("str_exec", O_ADDR);
    cyc("str_mem", O_STR_MEM);
    cyc("str_wb", O_DEF);

    // 3: BRR taken / not taken, BNE taken with absolute target
    opcode = 4'd5; mm = 4'b0010; stat = 4'b0010;
    cyc("brr_t_fetch", O_FETCH);
    cyc("brr_t_decode", O_BR_REL);
    stat = 4'b0000;
    cyc("brr_n_fetch", O_FETCH);
    cyc("brr_n_decode", O_DEF);
    opcode = 4'd6;
    cyc("bne_t_fetch", O_FETCH);
    cyc("bne_t_decode", O_BR_ABS);
    opcode = 4'd4;
    cyc("bra_n_fetch", O_FETCH);
    cyc("bra_n_decode", O_DEF);

    // 4: SWP, 6 cycles
    opcode = 4'd3;
    cyc("swp_fetch", O_FETCH);
    cyc("swp_decode", O_DEF);
    cyc("swp_exec", O_DEF);
    cyc("swp_mem", O_DEF);
    cyc("swp_wb", O_WB_ALU);
    cyc("swp_wb2", O_WB2);

    // Undefined opcode behaves as NOOP (5 cycles, defaults)
    opcode = 4'd11;
    cyc("nop_fetch", O_FETCH);
    cyc("nop_decode", O_DEF);
    cyc("nop_exec", O_DEF);
`ifndef SISC_SKIP_MEM_EN
    cyc("nop_mem", O_DEF);
`endif
    cyc("nop_wb", O_DEF);

    // 5: HLT held 20 cycles, then reset out of HALT
    opcode = 4'd15;
    cyc("hlt_fetch", O_FETCH);
    cyc("hlt_decode", O_DEF);
    for (int i = 0; i < 19; i++) cyc("halt", O_HALT);
    rst_f = 1'b1;
    cyc("halt_last", O_HALT);
    rst_f = 1'b0;
    cyc("halt_rst_start1", O_DEF);

    // 6: reset in the middle of STR's MEM cycle
    opcode = 4'd2;
    cyc("str2_fetch", O_FETCH);
    cyc("str2_decode", O_DEF);
    cyc("str2_exec", O_ADDR);
    rst_f = 1'b1;
    cyc("str2_mem", O_STR_MEM);
    rst_f = 1'b0;
    cyc("str2_rst_start1", O_DEF);
    run_alu(4'd8, O_ALU_IMM);
    cyc("final_fetch", O_FETCH);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
